register_sequencer: RTL and testbench
=====================================

Name: register_sequencer

Overview:
- Initiator/reader for the register memory. On a start pulse it walks memory addresses from 0 upward and fetches each 32-bit instruction word.
- Decodes each word and forwards write/read commands over a valid/ready handshake to the accelerometer bus controller.
- Stops on an END opcode, on a memory error, or on address overrun.
- Sits between register_memory and the SPI/I2C accelerometer controller.

Parameters:
- MEMORY_SIZE, 255: highest valid instruction address. Must match register_memory.
- ADDR_W, $clog2(MEMORY_SIZE+1) = 8: width of reg_addr. Localparam, not overridable.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a sequence at address 0. Ignored while busy.
- reg_addr  out  ADDR_W  address to register memory.
- reg_data  in  32  instruction word. Registered by memory: valid the cycle after reg_addr is presented.
- error_code  in  4  memory status, same timing as reg_data. Nonzero means invalid address.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  downstream accepts the command.
- cmd_write  out  1  1 = write, 0 = read.
- cmd_reg  out  8  device register address.
- cmd_data  out  8  write data. Driven as 0 for reads.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end, success or failure.
- err  out  1  sticky failure flag; cleared by the next accepted start.
- err_code  out  4  failure reason, valid while err is high.
- err_addr  out  ADDR_W  address being processed when the failure occurred.

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE.
  - reg_addr, cmd_*, busy, done, err, err_code, err_addr all go to 0.
  - Takes priority over every other event, including mid-handshake. cmd_valid drops with no completion.
- Instruction word format:
  - [31:24] opcode: 8'h00 NOP, 8'h01 WRITE, 8'h02 READ, 8'hFF END.
  - [23:16] cmd_reg.
  - [15:8] reserved, ignored.
  - [7:0] cmd_data.
- IDLE:
  - busy=0.
  - start=1: pc<=0, err<=0, err_code<=0, go to FETCH.
- FETCH: drive reg_addr=pc, busy=1, go to CAPTURE (1 cycle). reg_addr holds pc through CAPTURE.
- CAPTURE: latch reg_data and error_code, then take the first matching branch:
  - error_code!=0: err_code<=error_code, go to FAIL.
  - opcode 00 (NOP): go to ADVANCE.
  - opcode 01 or 02: load cmd_write, cmd_reg, cmd_data; set cmd_valid=1; go to ISSUE.
  - opcode FF (END): go to FINISH.
  - any other opcode: err_code<=4'h3, go to FAIL.
- ISSUE:
  - cmd_valid and payload held stable until cmd_valid && cmd_ready at a posedge.
  - On that handshake: cmd_valid<=0, go to ADVANCE.
  - cmd_valid never depends combinationally on cmd_ready.
- ADVANCE:
  - pc==MEMORY_SIZE: err_code<=4'h2 (overrun, no END found), go to FAIL.
  - Otherwise pc<=pc+1, go to FETCH. pc never wraps to 0.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- FAIL: err<=1, err_addr<=pc, done=1 for one cycle, go to IDLE.
- Throughput:
  - Minimum 3 cycles per NOP.
  - 3 cycles plus handshake wait per command; 4 cycles per command when cmd_ready is held high.
- start during busy: ignored. start in the same cycle done is high: ignored, since the FSM is not yet in IDLE.
- err_code values: 4'h1 (passed through from memory, invalid address), 4'h2 (overrun), 4'h3 (illegal opcode).

Decomposition:
- Package register_seq_pkg:
  - opcode_e enum (OP_NOP, OP_WRITE, OP_READ, OP_END).
  - state_e enum (IDLE, FETCH, CAPTURE, ISSUE, ADVANCE, FINISH, FAIL).
  - Error code constants.
  - instr_t packed struct for the word layout, shared with register_memory and the instruction-to-memory script.
- No sub-module needed. A single FSM plus pc counter is sufficient.

Test Plan:
1. Memory {0:01_20_00_57, 1:FF000000}, cmd_ready=1, start -> one command write=1 reg=8'h20 data=8'h57 accepted; done pulse; err=0; busy high throughout.
2. Memory {0:00000000, 1:02_0F_00_00, 2:FF..}, cmd_ready low 5 cycles -> cmd_valid high and payload (read, reg=8'h0F, data=0) stable for 5 cycles; accepted on the 6th; then done.
3. Memory returns error_code=1 at address 0 -> no command issued; done; err=1, err_code=4'h1, err_addr=0.
4. Word 0:7A000000 -> err=1, err_code=4'h3, err_addr=0. Next start clears err and the run completes normally.
5. All addresses NOP with MEMORY_SIZE=3 -> addresses 0..3 fetched in order; err_code=4'h2, err_addr=3; no wrap to 0.
6. Reset asserted while cmd_valid=1 and cmd_ready=0 -> next cycle all outputs 0, state IDLE; a later start re-fetches from address 0.

Source files
------------

// File: rtl/register_seq_pkg.sv
// Shared definitions for the register sequencer: opcodes, FSM states,
// failure codes and the instruction word layout used by register_memory
// and the instruction-to-memory script.
package register_seq_pkg;

    typedef enum logic [7:0] {
        OP_NOP   = 8'h00,
        OP_WRITE = 8'h01,
        OP_READ  = 8'h02,
        OP_END   = 8'hFF
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        ISSUE,
        ADVANCE,
        FINISH,
        FAIL
    } state_e;

    localparam logic [3:0] ERR_NONE    = 4'h0;
    localparam logic [3:0] ERR_MEM     = 4'h1;
    localparam logic [3:0] ERR_OVERRUN = 4'h2;
    localparam logic [3:0] ERR_OPCODE  = 4'h3;

    // Opcode is kept as raw bits so illegal values survive the unpacking
    // and can be reported instead of being coerced into an enum member.
    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] dev_reg;
        logic [7:0] reserved;
        logic [7:0] data;
    } instr_t;

endpackage

// File: rtl/register_sequencer.sv
// Walks register memory from address 0, decodes each instruction word and
// forwards write/read commands to the accelerometer bus controller over a
// valid/ready handshake. Stops on END, a memory error or address overrun.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; busy low
//   FETCH   | reg_addr = pc presented to memory
//   CAPTURE | memory word and status valid; decode and branch
//   ISSUE   | command held on cmd_* until cmd_ready
//   ADVANCE | step pc, or flag overrun at the last address
//   FINISH  | done pulse, clean end
//   FAIL    | done pulse, err/err_code/err_addr reporting the failure
module register_sequencer
    import register_seq_pkg::*;
#(
    parameter  int MEMORY_SIZE = 255,
    localparam int ADDR_W      = $clog2(MEMORY_SIZE + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [31:0]       reg_data,
    input  logic [3:0]        error_code,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [7:0]        cmd_reg,
    output logic [7:0]        cmd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        err_code,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEMORY_SIZE);

    state_e            state;
    logic [ADDR_W-1:0] pc;
    instr_t            word;
    logic [7:0]        unused_reserved;

    // The memory word is decoded directly in CAPTURE; the reserved byte is ignored.
    assign word            = instr_t'(reg_data);
    assign unused_reserved = word.reserved;

    // pc is held through FETCH and CAPTURE, so it drives the memory address directly.
    assign reg_addr = pc;

    // Sequencer FSM with registered outputs; done/err reporting is set on the
    // transition into FINISH/FAIL so it is valid during the done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= '0;
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_reg   <= 8'h00;
            cmd_data  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_addr  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pc       <= '0;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end

                FETCH: begin
                    state <= CAPTURE;
                end

                CAPTURE: begin
                    if (error_code != ERR_NONE) begin
                        err_code <= error_code;
                        err      <= 1'b1;
                        err_addr <= pc;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= FAIL;
                    end else begin
                        case (word.opcode)
                            OP_NOP: begin
                                state <= ADVANCE;
                            end
                            OP_WRITE, OP_READ: begin
                                cmd_write <= (word.opcode == OP_WRITE);
                                cmd_reg   <= word.dev_reg;
                                cmd_data  <= (word.opcode == OP_WRITE) ? word.data : 8'h00;
                                cmd_valid <= 1'b1;
                                state     <= ISSUE;
                            end
                            OP_END: begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= FINISH;
                            end
                            default: begin
                                err_code <= ERR_OPCODE;
                                err      <= 1'b1;
                                err_addr <= pc;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                state    <= FAIL;
                            end
                        endcase
                    end
                end

                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= ADVANCE;
                    end
                end

                ADVANCE: begin
                    if (pc == LAST_ADDR) begin
                        err_code <= ERR_OVERRUN;
                        err      <= 1'b1;
                        err_addr <= pc;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= FAIL;
                    end else begin
                        pc    <= pc + ADDR_W'(1);
                        state <= FETCH;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                FAIL: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_sequencer.sv
// Scoreboard bench for register_sequencer with a small registered memory model.
module tb_register_sequencer;
    import register_seq_pkg::*;

    localparam int MSIZE = 3;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_data;
    logic [3:0]    error_code;
    logic          cmd_valid;
    logic          cmd_ready = 1'b0;
    logic          cmd_write;
    logic [7:0]    cmd_reg;
    logic [7:0]    cmd_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [3:0]    err_code;
    logic [AW-1:0] err_addr;

    register_sequencer #(.MEMORY_SIZE(MSIZE)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .error_code (error_code),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_reg    (cmd_reg),
        .cmd_data   (cmd_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_done;
        bit            write;
        logic [7:0]    rg;
        logic [7:0]    data;
        int            stall;
        bit            err;
        logic [3:0]    code;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          fetch_log[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          done_seen = 0;
    logic [31:0] mem[4];
    logic [3:0]  merr[4];
    int          stall_req = 0;
    bit          hold_low = 1'b0;
    int          waited = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input bit w, input logic [7:0] r, input logic [7:0] d, input int stall);
        exp_t e;
        e = '{is_done: 1'b0, write: w, rg: r, data: d, stall: stall,
              err: 1'b0, code: 4'h0, addr: '0};
        sb.push_back(e);
    endtask

    task automatic push_done(input bit e_err, input logic [3:0] c, input logic [AW-1:0] a);
        exp_t e;
        e = '{is_done: 1'b1, write: 1'b0, rg: 8'h00, data: 8'h00, stall: 0,
              err: e_err, code: c, addr: a};
        sb.push_back(e);
    endtask

    // Registered memory: word and status valid the cycle after the address.
    always @(posedge clk) begin
        reg_data   <= mem[reg_addr];
        error_code <= merr[reg_addr];
    end

    // Downstream ready: optionally stalls a fixed number of cycles per command.
    always @(posedge clk) begin
        #1;
        if (hold_low) begin
            cmd_ready = 1'b0;
            waited    = 0;
        end else if (!cmd_valid) begin
            waited    = 0;
            cmd_ready = (stall_req == 0);
        end else if (!cmd_ready) begin
            if (waited < stall_req) waited++;
            else cmd_ready = 1'b1;
        end
    end

    // Address trace with consecutive repeats collapsed.
    always @(negedge clk) begin
        if (busy && (fetch_log.size() == 0 || fetch_log[$] != int'(reg_addr)))
            fetch_log.push_back(int'(reg_addr));
    end

    // Monitor: pops the scoreboard on each accepted command and each done pulse.
    logic [16:0] prev_payload;
    bit          prev_stall = 1'b0;
    int          stall_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset && cmd_valid && !cmd_ready) begin
            if (prev_stall) check("payload_stable", {15'd0, cmd_write, cmd_reg, cmd_data}, {15'd0, prev_payload});
            prev_payload = {cmd_write, cmd_reg, cmd_data};
            prev_stall   = 1'b1;
            stall_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
        if (reset && cmd_valid && cmd_ready) begin
            if (sb.size() == 0 || sb[0].is_done) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_cmd: got write=%0d reg=%0h data=%0h", cmd_write, cmd_reg, cmd_data);
            end else begin
                e = sb.pop_front();
                check("cmd_write", cmd_write, e.write);
                check("cmd_reg", cmd_reg, e.rg);
                check("cmd_data", cmd_data, e.data);
                check("cmd_stall", stall_cnt, e.stall);
                check("busy_in_cmd", busy, 1);
            end
            stall_cnt = 0;
        end
        if (!cmd_valid) stall_cnt = 0;
        if (reset && done) begin
            done_seen++;
            if (sb.size() == 0 || !sb[0].is_done) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got err=%0d code=%0h", err, err_code);
            end else begin
                e = sb.pop_front();
                check("done_err", err, e.err);
                check("done_code", err_code, e.code);
                if (e.err) check("done_addr", err_addr, e.addr);
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic run(input int budget);
        int seen0;
        seen0 = done_seen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < budget && done_seen == seen0; i++) @(negedge clk);
        vectors++;
        if (done_seen == seen0) begin
            miscompares++;
            $display("FAIL done_timeout: got no done within %0d cycles, required one", budget);
        end
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4; i++) begin
            mem[i]  = 32'h0;
            merr[i] = 4'h0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_mem();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd", {cmd_valid, cmd_write, cmd_reg, cmd_data}, 0);
        check("rst_status", {busy, done, err}, 0);
        check("rst_err", {err_code, err_addr}, 0);
        check("rst_addr", reg_addr, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single write then END, ready always high
        mem[0] = 32'h01200057;
        mem[1] = 32'hFF000000;
        push_cmd(1'b1, 8'h20, 8'h57, 0);
        push_done(1'b0, 4'h0, '0);
        run(50);

        // 2: NOP, read with 5 stall cycles, END; read data byte forced to 0
        clear_mem();
        mem[1] = 32'h020F0055;
        mem[2] = 32'hFF000000;
        stall_req = 5;
        repeat (2) @(negedge clk);
        push_cmd(1'b0, 8'h0F, 8'h00, 5);
        push_done(1'b0, 4'h0, '0);
        run(80);
        stall_req = 0;
        repeat (2) @(negedge clk);

        // 3: memory error at address 0
        clear_mem();
        mem[0]  = 32'h01200057;
        merr[0] = 4'h1;
        push_done(1'b1, 4'h1, 2'd0);
        run(50);
        check("err_sticky", err, 1);

        // 4: illegal opcode, then a clean run clears err
        clear_mem();
        mem[0] = 32'h7A000000;
        push_done(1'b1, 4'h3, 2'd0);
        run(50);
        mem[0] = 32'hFF000000;
        push_done(1'b0, 4'h0, '0);
        run(50);
        check("err_cleared", err, 0);

        // 5: all NOP -> overrun at the last address
        clear_mem();
        fetch_log.delete();
        push_done(1'b1, 4'h2, 2'd3);
        run(100);
        n = fetch_log.size();
        check("fetch_cnt", n, 4);
        for (int i = 0; i < 4; i++)
            if (i < n) check("fetch_addr", fetch_log[i], i);

        // 6: reset during a stalled command, then a fresh run from address 0
        clear_mem();
        mem[0] = 32'h01330044;
        mem[1] = 32'hFF000000;
        hold_low = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !cmd_valid; i++) @(negedge clk);
        check("stalled_valid", cmd_valid, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_cmd", {cmd_valid, cmd_write, cmd_reg, cmd_data}, 0);
        check("midrst_status", {busy, done, err}, 0);
        check("midrst_addr", reg_addr, 0);
        reset = 1'b1;
        hold_low = 1'b0;
        repeat (2) @(negedge clk);
        fetch_log.delete();
        push_cmd(1'b1, 8'h33, 8'h44, 0);
        push_done(1'b0, 4'h0, '0);
        run(50);
        n = fetch_log.size();
        check("refetch_cnt", n, 2);
        if (n > 0) check("refetch_first", fetch_log[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
